// File: rtl/mem_stage.sv
// Memory-access pipeline stage: waits for the data-SRAM response, buffers it
// when WB stalls, extends load data, and discards responses of flushed requests.
module mem_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        es2ms_valid,
  output logic        ms_allowin,
  input  logic        es_mem_req,
  input  logic [4:0]  es_ld_op,
  input  logic [31:0] es_pc,
  input  logic [31:0] es_result,
  input  logic        es_rf_we,
  input  logic [4:0]  es_rf_waddr,
  input  logic        es_ex,
  input  logic        data_sram_data_ok,
  input  logic [31:0] data_sram_rdata,
  input  logic        ws_allowin,
  output logic        ms2ws_valid,
  output logic [31:0] ms_pc,
  output logic        ms_rf_we,
  output logic [4:0]  ms_rf_waddr,
  output logic [31:0] ms_rf_wdata,
  output logic        ms_ex_out,
  output logic        ms_ex,
  output logic        ms_fwd_blk,
  input  logic        wb_ex
);

  logic        ms_valid_q, ms_valid_d;
  logic        buf_valid_q, buf_valid_d;
  logic [31:0] buf_q, buf_d;
  logic [1:0]  drop_cnt_q, drop_cnt_d;

  logic        mem_req_q;
  logic [4:0]  ld_op_q;
  logic [31:0] pc_q;
  logic [31:0] result_q;
  logic        rf_we_q;
  logic [4:0]  rf_waddr_q;
  logic        ex_q;

  logic        data_ok_eff;
  logic        ms_wait;
  logic        ms_ready_go;
  logic        ms_leave;
  logic        drop_inc;
  logic        drop_dec;
  logic [31:0] rdata;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] ld_data;

  // A response is only ours when no flushed request is still outstanding.
  assign data_ok_eff = data_sram_data_ok & (drop_cnt_q == 2'd0);
  assign ms_wait     = ms_valid_q & mem_req_q & ~ex_q & ~buf_valid_q;
  assign ms_ready_go = ~ms_wait | data_ok_eff;
  assign ms_allowin  = ~ms_valid_q | (ms_ready_go & ws_allowin);
  assign ms2ws_valid = ms_valid_q & ms_ready_go & ~wb_ex;
  assign ms_leave    = ms_valid_q & ms_ready_go & ws_allowin;

  assign drop_inc = wb_ex & ms_wait & ~data_ok_eff;
  assign drop_dec = data_sram_data_ok & (drop_cnt_q != 2'd0);

  always_comb begin
    ms_valid_d = ms_valid_q;
    if (wb_ex)
      ms_valid_d = 1'b0;
    else if (ms_allowin)
      ms_valid_d = es2ms_valid;
  end

  always_comb begin
    buf_valid_d = buf_valid_q;
    buf_d       = buf_q;
    if (wb_ex) begin
      buf_valid_d = 1'b0;
    end else if (ms_wait & data_ok_eff & ~ws_allowin) begin
      buf_valid_d = 1'b1;
      buf_d       = data_sram_rdata;
    end else if (ms_leave) begin
      buf_valid_d = 1'b0;
    end
  end

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop_inc && !drop_dec && drop_cnt_q != 2'd3)
      drop_cnt_d = drop_cnt_q + 2'd1;
    else if (drop_dec && !drop_inc)
      drop_cnt_d = drop_cnt_q - 2'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ms_valid_q  <= 1'b0;
      buf_valid_q <= 1'b0;
      buf_q       <= 32'h0;
      drop_cnt_q  <= 2'd0;
    end else begin
      ms_valid_q  <= ms_valid_d;
      buf_valid_q <= buf_valid_d;
      buf_q       <= buf_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_req_q  <= 1'b0;
      ld_op_q    <= 5'h0;
      pc_q       <= 32'h0;
      result_q   <= 32'h0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= 5'h0;
      ex_q       <= 1'b0;
    end else if (es2ms_valid & ms_allowin) begin
      mem_req_q  <= es_mem_req;
      ld_op_q    <= es_ld_op;
      pc_q       <= es_pc;
      result_q   <= es_result;
      rf_we_q    <= es_rf_we;
      rf_waddr_q <= es_rf_waddr;
      ex_q       <= es_ex;
    end
  end

  assign rdata = buf_valid_q ? buf_q : data_sram_rdata;

  // ld_op bit order: {ld_b, ld_bu, ld_h, ld_hu, ld_w}
  always_comb begin
    byte_sel = 8'h0;
    half_sel = 16'h0;
    ld_data  = rdata;
    case (result_q[1:0])
      2'd0: byte_sel = rdata[7:0];
      2'd1: byte_sel = rdata[15:8];
      2'd2: byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = result_q[1] ? rdata[31:16] : rdata[15:0];
    if (ld_op_q[4])
      ld_data = {{24{byte_sel[7]}}, byte_sel};
    else if (ld_op_q[3])
      ld_data = {24'h0, byte_sel};
    else if (ld_op_q[2])
      ld_data = {{16{half_sel[15]}}, half_sel};
    else if (ld_op_q[1])
      ld_data = {16'h0, half_sel};
  end

  assign ms_rf_wdata = (|ld_op_q) ? ld_data : result_q;
  assign ms_pc       = pc_q;
  assign ms_rf_waddr = rf_waddr_q;
  assign ms_rf_we    = rf_we_q & ms_valid_q & ~ex_q;
  assign ms_ex       = ms_valid_q & ex_q;
  assign ms_ex_out   = ms_ex;
  assign ms_fwd_blk  = ms_valid_q & (|ld_op_q) & ms_wait & ~data_ok_eff;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: inputs change 1ns after a rising edge,
// outputs are compared mid-cycle against hand-computed values.
module tb_mem_stage;
  logic        clk = 1'b0;
  logic        reset;
  logic        es2ms_valid;
  logic        ms_allowin;
  logic        es_mem_req;
  logic [4:0]  es_ld_op;
  logic [31:0] es_pc;
  logic [31:0] es_result;
  logic        es_rf_we;
  logic [4:0]  es_rf_waddr;
  logic        es_ex;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic        ws_allowin;
  logic        ms2ws_valid;
  logic [31:0] ms_pc;
  logic        ms_rf_we;
  logic [4:0]  ms_rf_waddr;
  logic [31:0] ms_rf_wdata;
  logic        ms_ex_out;
  logic        ms_ex;
  logic        ms_fwd_blk;
  logic        wb_ex;

  int n_chk = 0;
  int n_err = 0;

  localparam logic [4:0] LD_B  = 5'b10000;
  localparam logic [4:0] LD_HU = 5'b00010;
  localparam logic [4:0] LD_W  = 5'b00001;

  mem_stage dut (
    .clk(clk), .reset(reset),
    .es2ms_valid(es2ms_valid), .ms_allowin(ms_allowin),
    .es_mem_req(es_mem_req), .es_ld_op(es_ld_op), .es_pc(es_pc),
    .es_result(es_result), .es_rf_we(es_rf_we), .es_rf_waddr(es_rf_waddr),
    .es_ex(es_ex), .data_sram_data_ok(data_sram_data_ok),
    .data_sram_rdata(data_sram_rdata), .ws_allowin(ws_allowin),
    .ms2ws_valid(ms2ws_valid), .ms_pc(ms_pc), .ms_rf_we(ms_rf_we),
    .ms_rf_waddr(ms_rf_waddr), .ms_rf_wdata(ms_rf_wdata),
    .ms_ex_out(ms_ex_out), .ms_ex(ms_ex), .ms_fwd_blk(ms_fwd_blk),
    .wb_ex(wb_ex)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    #4;
  endtask

  task automatic offer(input logic mreq, input logic [4:0] op, input logic [31:0] pc,
                       input logic [31:0] res, input logic ex);
    es2ms_valid = 1'b1;
    es_mem_req  = mreq;
    es_ld_op    = op;
    es_pc       = pc;
    es_result   = res;
    es_rf_we    = 1'b1;
    es_rf_waddr = 5'd5;
    es_ex       = ex;
  endtask

  initial begin
    reset = 1'b1;
    es2ms_valid = 0; es_mem_req = 0; es_ld_op = 0; es_pc = 0; es_result = 0;
    es_rf_we = 0; es_rf_waddr = 0; es_ex = 0; data_sram_data_ok = 0;
    data_sram_rdata = 0; ws_allowin = 1; wb_ex = 0;
    #12;
    check("rst_allowin", {31'h0, ms_allowin}, 32'h1);
    check("rst_ms2ws", {31'h0, ms2ws_valid}, 32'h0);
    check("rst_ex", {31'h0, ms_ex}, 32'h0);
    check("rst_fwd_blk", {31'h0, ms_fwd_blk}, 32'h0);
    check("rst_rf_we", {31'h0, ms_rf_we}, 32'h0);
    check("rst_wdata", ms_rf_wdata, 32'h0);
    check("rst_pc", ms_pc, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    tick();

    // ld_b at byte 3, response in the cycle after entry
    offer(1'b1, LD_B, 32'h100, 32'h1003, 1'b0);
    mid();
    check("ldb_allowin", {31'h0, ms_allowin}, 32'h1);
    tick();
    es2ms_valid = 0;
    #2;
    check("ldb_fwd_blk_wait", {31'h0, ms_fwd_blk}, 32'h1);
    check("ldb_no_go", {31'h0, ms2ws_valid}, 32'h0);
    data_sram_data_ok = 1; data_sram_rdata = 32'h80FF_FFFF;
    #2;
    check("ldb_go", {31'h0, ms2ws_valid}, 32'h1);
    check("ldb_wdata", ms_rf_wdata, 32'hFFFF_FF80);
    check("ldb_rf_we", {31'h0, ms_rf_we}, 32'h1);
    check("ldb_pc", ms_pc, 32'h100);
    check("ldb_fwd_blk_ok", {31'h0, ms_fwd_blk}, 32'h0);
    tick();
    data_sram_data_ok = 0;
    mid();
    check("ldb_gone", {31'h0, ms2ws_valid}, 32'h0);

    // ld_hu with WB stalled when the response arrives: buffered
    tick();
    offer(1'b1, LD_HU, 32'h200, 32'h2002, 1'b0);
    ws_allowin = 0;
    tick();
    es2ms_valid = 0;
    data_sram_data_ok = 1; data_sram_rdata = 32'hBEEF_1234;
    mid();
    check("ldhu_allowin_stall", {31'h0, ms_allowin}, 32'h0);
    tick();
    data_sram_data_ok = 0; data_sram_rdata = 32'hFFFF_FFFF;
    mid();
    check("ldhu_buf_valid", {31'h0, dut.buf_valid_q}, 32'h1);
    check("ldhu_fwd_blk", {31'h0, ms_fwd_blk}, 32'h0);
    check("ldhu_wdata_buf", ms_rf_wdata, 32'h0000_BEEF);
    tick();
    tick();
    ws_allowin = 1;
    mid();
    check("ldhu_wdata", ms_rf_wdata, 32'h0000_BEEF);
    check("ldhu_go", {31'h0, ms2ws_valid}, 32'h1);
    check("ldhu_allowin", {31'h0, ms_allowin}, 32'h1);
    tick();
    mid();
    check("ldhu_buf_clr", {31'h0, dut.buf_valid_q}, 32'h0);

    // flushed load leaves an orphan response that must be discarded
    tick();
    offer(1'b1, LD_W, 32'h300, 32'h3000, 1'b0);
    tick();
    es2ms_valid = 0;
    wb_ex = 1;
    mid();
    check("flush_no_go", {31'h0, ms2ws_valid}, 32'h0);
    tick();
    wb_ex = 0;
    offer(1'b1, LD_W, 32'h304, 32'h3004, 1'b0);
    mid();
    check("flush_drop1", {30'h0, dut.drop_cnt_q}, 32'h1);
    check("flush_allowin", {31'h0, ms_allowin}, 32'h1);
    tick();
    es2ms_valid = 0;
    data_sram_data_ok = 1; data_sram_rdata = 32'hDEAD_DEAD;
    mid();
    check("orphan_discard", {31'h0, ms2ws_valid}, 32'h0);
    check("orphan_fwd_blk", {31'h0, ms_fwd_blk}, 32'h1);
    tick();
    data_sram_rdata = 32'h1234_5678;
    mid();
    check("orphan_drop0", {30'h0, dut.drop_cnt_q}, 32'h0);
    check("ldw_go", {31'h0, ms2ws_valid}, 32'h1);
    check("ldw_wdata", ms_rf_wdata, 32'h1234_5678);
    check("ldw_pc", ms_pc, 32'h304);
    tick();
    data_sram_data_ok = 0;

    // upstream exception: no response awaited
    tick();
    offer(1'b1, 5'h0, 32'h400, 32'h0, 1'b1);
    es_mem_req = 0;
    ws_allowin = 0;
    tick();
    es2ms_valid = 0;
    mid();
    check("ex_ms_ex", {31'h0, ms_ex}, 32'h1);
    check("ex_ex_out", {31'h0, ms_ex_out}, 32'h1);
    check("ex_rf_we", {31'h0, ms_rf_we}, 32'h0);
    check("ex_go", {31'h0, ms2ws_valid}, 32'h1);
    tick();
    ws_allowin = 1;
    tick();
    mid();
    check("ex_gone", {31'h0, ms_ex}, 32'h0);

    // flush in the same cycle as the awaited response
    tick();
    offer(1'b1, LD_W, 32'h500, 32'h5000, 1'b0);
    tick();
    es2ms_valid = 0;
    wb_ex = 1; data_sram_data_ok = 1; data_sram_rdata = 32'hAAAA_5555;
    mid();
    check("flushok_no_go", {31'h0, ms2ws_valid}, 32'h0);
    tick();
    wb_ex = 0; data_sram_data_ok = 0;
    mid();
    check("flushok_drop0", {30'h0, dut.drop_cnt_q}, 32'h0);
    check("flushok_empty", {31'h0, ms_allowin}, 32'h1);

    // ALU op held by WB stall, then passed through
    tick();
    offer(1'b0, 5'h0, 32'h600, 32'h5555_AAAA, 1'b0);
    es_rf_waddr = 5'd7;
    ws_allowin = 0;
    tick();
    offer(1'b0, 5'h0, 32'h604, 32'h1111_2222, 1'b0);
    mid();
    check("alu_allowin0", {31'h0, ms_allowin}, 32'h0);
    check("alu_wdata_h1", ms_rf_wdata, 32'h5555_AAAA);
    tick();
    mid();
    check("alu_wdata_h2", ms_rf_wdata, 32'h5555_AAAA);
    check("alu_pc_h2", ms_pc, 32'h600);
    check("alu_waddr", {27'h0, ms_rf_waddr}, 32'h7);
    tick();
    ws_allowin = 1;
    mid();
    check("alu_allowin1", {31'h0, ms_allowin}, 32'h1);
    check("alu_go", {31'h0, ms2ws_valid}, 32'h1);
    tick();
    es2ms_valid = 0;
    mid();
    check("alu_next_pc", ms_pc, 32'h604);
    check("alu_next_wdata", ms_rf_wdata, 32'h1111_2222);

    // orphan pending while a second flush coincides with its response
    tick();
    offer(1'b1, LD_W, 32'h700, 32'h7000, 1'b0);
    tick();
    es2ms_valid = 0; wb_ex = 1;
    tick();
    wb_ex = 0;
    offer(1'b1, LD_W, 32'h704, 32'h7004, 1'b0);
    tick();
    es2ms_valid = 0; wb_ex = 1; data_sram_data_ok = 1;
    tick();
    wb_ex = 0; data_sram_data_ok = 0;
    mid();
    check("incdec_drop1", {30'h0, dut.drop_cnt_q}, 32'h1);
    tick();
    data_sram_data_ok = 1;
    tick();
    data_sram_data_ok = 0;
    mid();
    check("incdec_drop0", {30'h0, dut.drop_cnt_q}, 32'h0);

    // reset in the middle of a pending request
    tick();
    offer(1'b1, LD_W, 32'h800, 32'h8000, 1'b0);
    tick();
    es2ms_valid = 0;
    reset = 1;
    mid();
    check("midrst_allowin", {31'h0, ms_allowin}, 32'h1);
    check("midrst_pc", ms_pc, 32'h0);
    reset = 0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
